blink_requester: RTL
====================

// Module: blink_requester
// PURPOSE
//  Initiator side of the blink handshake. Lock control logic raises one-cycle event
//  pulses (wrong code, programming success). This block queues them, drives
//  start_blinking/blink_type into the LED blinker, and waits on done_blinking. Each
//  queued event plays in order, with a fixed gap between blinks. A watchdog recovers
//  the block if the blinker stalls.
// PARAMETERS
//  DEPTH        4              request queue entries (power of 2, >=2)
//  START_PULSE  4              cycles start_blinking is held high per request
//  ACK_TIMEOUT  16             max cycles from start rise to done_blinking falling
//  DONE_TIMEOUT 32'd72000000   max cycles waiting for done_blinking high (6 s @ 12 MHz)
//  GAP_CYCLES   32'd1200000    dark gap between consecutive blinks (0.1 s)
// PORTS
//  hwclk          in   1   system clock (12 MHz)
//  rst            in   1   asynchronous reset, active-high
//  err_req        in   1   1-cycle pulse: request error blink (type 0)
//  prog_req       in   1   1-cycle pulse: request programming-OK blink (type 1)
//  done_blinking  in   1   from blinker: 1 = idle/finished, 0 = blinking
//  start_blinking out  1   to blinker: start strobe, held START_PULSE cycles
//  blink_type     out  1   to blinker: 0 = error, 1 = prog OK; stable ISSUE..WAIT_DONE
//  busy           out  1   1 whenever state != IDLE or queue non-empty
//  pending_count  out  $clog2(DEPTH)+1  queued, not-yet-issued requests
//  overflow       out  1   sticky: a request was dropped
//  timeout        out  1   sticky: the watchdog fired
// BEHAVIOUR
//  Reset (async, any time, including mid-blink): all outputs 0; queue flushed;
//   state IDLE; timers 0. Sticky flags clear only on rst.
//  Enqueue: when err_req or prog_req is sampled high, one entry is written at that edge.
//   If both are high in the same cycle, err wins; prog is dropped and overflow is set.
//   When the queue is full, the request is dropped and overflow is set, unless a pop
//   happens in the same cycle; then the request is accepted.
//   Simultaneous push and pop leaves pending_count unchanged.
//  FSM: IDLE -> ISSUE -> WAIT_LOW -> WAIT_DONE -> GAP -> IDLE.
//   IDLE: if the queue is non-empty, pop the head and latch it into blink_type.
//    Go to ISSUE. The pop is registered.
//   ISSUE: start_blinking=1 for exactly START_PULSE cycles, then go to WAIT_LOW.
//    start_blinking is low in every other state.
//   WAIT_LOW: this counter starts at the start_blinking rise.
//    If done_blinking is 0, go to WAIT_DONE.
//    If done_blinking is still 1 after ACK_TIMEOUT cycles, set timeout and go to GAP.
//   WAIT_DONE: on done_blinking==1, go to GAP.
//    After DONE_TIMEOUT cycles with no done, set timeout and go to GAP.
//   GAP: wait GAP_CYCLES with outputs quiet, then go to IDLE.
//    blink_type returns to 0 in GAP.
//  Latency: a request sampled at edge N while IDLE and the queue is empty produces
//   start_blinking=1 after edge N+2.
//  Timers are 32-bit, saturate, and reset on every state entry. Comparisons are
//   >= and unsigned. Queue pointers wrap modulo DEPTH.
//  A timed-out event is discarded and never retried. Queued events are still served.
// STRUCTURE
//  blink_pkg: BLINK_ERROR=1'b0, BLINK_PROG=1'b1, FSM state enum (IDLE, ISSUE,
//   WAIT_LOW, WAIT_DONE, GAP), CLK_HZ=12000000.
//  Sub-module blink_req_fifo: 1-bit-wide, DEPTH-deep synchronous FIFO.
//   Ports: push, pop, din, dout, full, empty, count. Behaviour: accepts a push when
//   full if pop is also asserted.
//  The top level holds the FSM, one shared 32-bit timer, the sticky flags, and the
//   priority merge of the two request inputs.
// TESTING  (bench: START_PULSE=4, ACK_TIMEOUT=16, DONE_TIMEOUT=100, GAP_CYCLES=3; blinker model)
//  1 Single err_req at idle -> start_blinking high for 4 cycles from edge N+2,
//    blink_type=0; model drops done for 20 cycles; busy falls 3 cycles after done returns.
//  2 err_req then prog_req 1 cycle apart -> two blinks in order, types 0 then 1,
//    separated by >= 3 gap cycles; pending_count goes 1,2,1,0.
//  3 6 prog_req pulses while the first blink runs (DEPTH=4) -> 4 queued, excess dropped;
//    overflow=1; exactly 5 blinks issued in total.
//  4 err_req and prog_req in the same cycle -> one type-0 blink; overflow=1.
//  5 Blinker never drops done -> timeout=1 at 16 cycles; FSM goes to GAP then IDLE and
//    serves the next queued event. Blinker drops done but never returns it -> timeout
//    at 100 cycles.
//  6 rst asserted mid-WAIT_DONE with 2 queued -> all outputs 0 immediately and queue empty;
//    a fresh err_req after rst release is served normally.

Source files
------------

// File: rtl/blink_pkg.sv
// blink_pkg
//   Shared definitions for the blink requester: blink type encodings, the
//   requester FSM state type, the system clock rate and small timer helpers.
package blink_pkg;

  localparam logic BLINK_ERROR = 1'b0;  // wrong-code blink
  localparam logic BLINK_PROG  = 1'b1;  // programming-OK blink

  localparam int CLK_HZ = 12000000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_DONE,
    GAP
  } blink_state_t;

  // 32-bit saturating increment: a stuck state can never wrap the timer back
  // to a small value and hide a timeout.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // True on the cycle whose closing edge completes 'lim' cycles in the
  // current timing window. The timer reads 0 during the first cycle, so the
  // test is t + 1 >= lim, done in 33 bits so it cannot overflow.
  function automatic logic limit_reached(input logic [31:0] t, input logic [31:0] lim);
    return ({1'b0, t} + 33'd1) >= {1'b0, lim};
  endfunction

endpackage

// File: rtl/blink_req_fifo.sv
// blink_req_fifo
//   1-bit wide, DEPTH-deep synchronous FIFO holding pending blink types.
//   A push against a full FIFO is still accepted when a pop happens in the
//   same cycle. The head entry is visible on o_dout without a read latency.
// Ports
//   i_clk    in   clock
//   i_rst    in   asynchronous reset, active-high (flushes the FIFO)
//   i_push   in   write i_din this cycle
//   i_pop    in   remove the head entry this cycle
//   i_din    in   entry to write
//   o_dout   out  current head entry
//   o_full   out  DEPTH entries stored
//   o_empty  out  no entries stored
//   o_count  out  number of stored entries
module blink_req_fifo
  import blink_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_din,
  output logic                     o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  // Tiny storage, kept in flops so the head is readable in the same cycle.
  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  // Space freed by a simultaneous pop lets a push through when full.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/blink_requester.sv
// blink_requester
//   Initiator side of the blink handshake. Merges error / programming-OK
//   event pulses into a request queue, then plays each queued event on the
//   LED blinker: start strobe, wait for the blinker to go busy, wait for it
//   to finish, then a dark gap. A shared watchdog timer recovers from a
//   blinker that never acknowledges or never finishes.
// Ports
//   i_hwclk           in   system clock
//   i_rst             in   asynchronous reset, active-high
//   i_err_req         in   1-cycle pulse: queue an error blink
//   i_prog_req        in   1-cycle pulse: queue a programming-OK blink
//   i_done_blinking   in   blinker status: 1 idle/finished, 0 blinking
//   o_start_blinking  out  start strobe, high START_PULSE cycles per blink
//   o_blink_type      out  type of the blink in flight (0 error, 1 prog OK)
//   o_busy            out  FSM active or queue non-empty
//   o_pending_count   out  queued, not-yet-issued requests
//   o_overflow        out  sticky: a request was dropped
//   o_timeout         out  sticky: the watchdog fired
module blink_requester
  import blink_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] START_PULSE  = 32'd4,
  parameter logic [31:0] ACK_TIMEOUT  = 32'd16,
  parameter logic [31:0] DONE_TIMEOUT = 32'd72000000,
  parameter logic [31:0] GAP_CYCLES   = 32'd1200000
) (
  input  logic                   i_hwclk,
  input  logic                   i_rst,
  input  logic                   i_err_req,
  input  logic                   i_prog_req,
  input  logic                   i_done_blinking,
  output logic                   o_start_blinking,
  output logic                   o_blink_type,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_pending_count,
  output logic                   o_overflow,
  output logic                   o_timeout
);

  blink_state_t r_state;
  blink_state_t w_next_state;
  logic [31:0]  r_timer;
  logic         r_pop_pending;
  logic         w_pop_pending_next;
  logic         r_type;
  logic         r_overflow;
  logic         r_timeout;

  logic         w_push;
  logic         w_din;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic         w_dout;
  logic         w_set_timeout;
  logic         w_set_overflow;
  logic         w_timer_clear;

  // Request merge: an error report always wins over a simultaneous
  // programming-OK report; the loser counts as a dropped request.
  assign w_push = i_err_req || i_prog_req;
  assign w_din  = i_err_req ? BLINK_ERROR : BLINK_PROG;

  assign w_set_overflow = (i_err_req && i_prog_req) || (w_push && w_full && !w_pop);

  blink_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk   (i_hwclk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_pending_count)
  );

  // The acknowledge window runs from the start strobe rise, so the timer keeps
  // counting across ISSUE -> WAIT_LOW. Every other state entry restarts it.
  assign w_timer_clear = (w_next_state != r_state) &&
                         !((r_state == ISSUE) && (w_next_state == WAIT_LOW));

  // State register and datapath registers
  always_ff @(posedge i_hwclk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_timer       <= 32'd0;
      r_pop_pending <= 1'b0;
      r_type        <= BLINK_ERROR;
      r_overflow    <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_timer       <= w_timer_clear ? 32'd0 : sat_inc(r_timer);
      r_pop_pending <= w_pop_pending_next;
      if (w_pop) begin
        r_type <= w_dout;
      end else if (w_next_state == GAP) begin
        r_type <= BLINK_ERROR;
      end
      if (w_set_overflow) begin
        r_overflow <= 1'b1;
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state       = r_state;
    w_pop              = 1'b0;
    w_pop_pending_next = r_pop_pending;
    w_set_timeout      = 1'b0;
    case (r_state)
      IDLE: begin
        // A non-empty queue first arms a registered pop; the head is removed
        // and latched on the following edge, together with entry into ISSUE.
        if (r_pop_pending) begin
          w_pop              = 1'b1;
          w_pop_pending_next = 1'b0;
          w_next_state       = ISSUE;
        end else if (!w_empty) begin
          w_pop_pending_next = 1'b1;
        end
      end
      ISSUE: begin
        if (limit_reached(r_timer, START_PULSE)) begin
          w_next_state = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!i_done_blinking) begin
          w_next_state = WAIT_DONE;
        end else if (limit_reached(r_timer, ACK_TIMEOUT)) begin
          w_set_timeout = 1'b1;
          w_next_state  = GAP;
        end
      end
      WAIT_DONE: begin
        if (i_done_blinking) begin
          w_next_state = GAP;
        end else if (limit_reached(r_timer, DONE_TIMEOUT)) begin
          w_set_timeout = 1'b1;
          w_next_state  = GAP;
        end
      end
      GAP: begin
        if (limit_reached(r_timer, GAP_CYCLES)) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    o_start_blinking = 1'b0;
    o_blink_type     = 1'b0;
    case (r_state)
      ISSUE: begin
        o_start_blinking = 1'b1;
        o_blink_type     = r_type;
      end
      WAIT_LOW, WAIT_DONE: begin
        o_blink_type = r_type;
      end
      default: begin
      end
    endcase
    o_busy = (r_state != IDLE) || !w_empty;
  end

  assign o_overflow = r_overflow;
  assign o_timeout  = r_timeout;

endmodule
